// File: rtl/phase_pkg.sv
// ---------------------------------------------------------------------------
// phase_pkg
// Shared definitions for the phase sequencer: state encodings (also driven
// out on the `phase` port), the phase width and the default MEM_WAIT limit.
// ---------------------------------------------------------------------------
package phase_pkg;

    localparam int PHASE_W          = 3;
    localparam int MEM_WAIT_MAX_DEF = 15;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_IF       = 3'd1,
        ST_ID       = 3'd2,
        ST_ALU      = 3'd3,
        ST_MEM      = 3'd4,
        ST_MEM_WAIT = 3'd5,
        ST_RB       = 3'd6,
        ST_HALTED   = 3'd7
    } phase_e;

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts the cycles spent in MEM_WAIT and flags the cycle in which the
// count reaches MEM_WAIT_MAX.
//
// Ports:
//   clk      in   master clock
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   clear    in   zero the count (asserted during the MEM cycle)
//   enable   in   advance the count (asserted during MEM_WAIT cycles)
//   expired  out  combinational; high in the MEM_WAIT cycle whose increment
//                 brings the count to MEM_WAIT_MAX, so the FSM spends exactly
//                 MEM_WAIT_MAX cycles in MEM_WAIT before the forced exit
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MEM_WAIT_MAX);
    localparam logic [WAIT_W-1:0] ONE_C = WAIT_W'(1);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;
    logic [WAIT_W-1:0] count_inc;

    assign count_inc = count_q + ONE_C;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_inc;
        end
    end

    // Compare the post-increment value: the first MEM_WAIT cycle sees
    // count_q = 0, so the MEM_WAIT_MAX-th cycle is the one that expires.
    assign expired = enable && !clear && (count_inc == MAX_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
// Generates the five phase strobes (IF, ID, ALU, MEM, RB/BR) for the
// multi-cycle control unit from one master clock. MEM is skipped for
// non-memory instructions and stretched by wait states until mem_ready or
// a MEM_WAIT_MAX timeout. Once halt is seen the sequencer parks in HALTED
// until reset.
//
// Optional feature (macro PHASE_SEQ_PERF_EN): adds cycle_cnt / instr_cnt
// performance counters.
//
// Ports:
//   clk          in   master clock
//   rst_n        in   asynchronous active-low reset
//   run          in   keep issuing instructions (sampled in IDLE and RB)
//   halt         in   halt request (sampled in ALU and RB)
//   mem_access   in   instruction is a load/store (sampled in ALU)
//   mem_ready    in   memory done (sampled in MEM and MEM_WAIT)
//   IF_clk .. RB_BR_clk  out  registered one-hot phase strobes
//   phase        out  current state encoding
//   instr_done   out  pulse coincident with RB_BR_clk
//   halted       out  high while in HALTED
//   mem_timeout  out  sticky, set on a forced MEM_WAIT exit
//   cycle_cnt    out  (PHASE_SEQ_PERF_EN) active cycles, frozen in IDLE/HALTED
//   instr_cnt    out  (PHASE_SEQ_PERF_EN) completed instructions
// ---------------------------------------------------------------------------
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
    parameter int WAIT_W       = 8,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               halt,
    input  logic               mem_access,
    input  logic               mem_ready,
    output logic               IF_clk,
    output logic               ID_clk,
    output logic               ALU_clk,
    output logic               MEM_clk,
    output logic               RB_BR_clk,
    output logic [PHASE_W-1:0] phase,
    output logic               instr_done,
    output logic               halted,
    output logic               mem_timeout
`ifdef PHASE_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt
`endif
);

    phase_e state_q;
    phase_e state_d;

    logic if_q;
    logic id_q;
    logic alu_q;
    logic mem_q;
    logic rb_q;
    logic done_q;
    logic halted_q;
    logic timeout_q;

    logic timer_expired;
    logic timeout_set;

    mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .WAIT_W       (WAIT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == ST_MEM),
        .enable  (state_q == ST_MEM_WAIT),
        .expired (timer_expired)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     state_d = run ? ST_IF : ST_IDLE;
            ST_IF:       state_d = ST_ID;
            ST_ID:       state_d = ST_ALU;
            ST_ALU: begin
                if (halt)            state_d = ST_HALTED;
                else if (mem_access) state_d = ST_MEM;
                else                 state_d = ST_RB;
            end
            ST_MEM:      state_d = mem_ready ? ST_RB : ST_MEM_WAIT;
            ST_MEM_WAIT: state_d = (mem_ready || timer_expired) ? ST_RB : ST_MEM_WAIT;
            ST_RB: begin
                if (halt)      state_d = ST_HALTED;
                else if (!run) state_d = ST_IDLE;
                else           state_d = ST_IF;
            end
            ST_HALTED:   state_d = ST_HALTED;
            default:     state_d = ST_IDLE;
        endcase
    end

    // A completed memory access on the expiry cycle is not a timeout.
    assign timeout_set = (state_q == ST_MEM_WAIT) && !mem_ready && timer_expired;

    // Outputs are decoded from the next state and registered, so each strobe
    // rises together with the state it belongs to and stays glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            if_q      <= 1'b0;
            id_q      <= 1'b0;
            alu_q     <= 1'b0;
            mem_q     <= 1'b0;
            rb_q      <= 1'b0;
            done_q    <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            if_q      <= (state_d == ST_IF);
            id_q      <= (state_d == ST_ID);
            alu_q     <= (state_d == ST_ALU);
            mem_q     <= (state_d == ST_MEM);
            rb_q      <= (state_d == ST_RB);
            done_q    <= (state_d == ST_RB);
            halted_q  <= (state_d == ST_HALTED);
            timeout_q <= timeout_q | timeout_set;
        end
    end

    assign IF_clk      = if_q;
    assign ID_clk      = id_q;
    assign ALU_clk     = alu_q;
    assign MEM_clk     = mem_q;
    assign RB_BR_clk   = rb_q;
    assign instr_done  = done_q;
    assign halted      = halted_q;
    assign mem_timeout = timeout_q;
    assign phase       = state_q;

`ifdef PHASE_SEQ_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] instr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != ST_IDLE && state_q != ST_HALTED) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            // instr_done is never high in HALTED, so this freezes there too.
            if (done_q) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
// Directed cycle-by-cycle check of the phase sequencer. Every cycle the
// observed {phase, strobes, instr_done, halted, mem_timeout} is compared
// against a hand-written expectation. Counter checks are compiled in when
// PHASE_SEQ_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_phase_sequencer;

    // flag vector layout: {IF, ID, ALU, MEM, RB, instr_done, halted, mem_timeout}
    localparam logic [7:0] F_NONE = 8'b0000_0000;
    localparam logic [7:0] F_IF   = 8'b1000_0000;
    localparam logic [7:0] F_ID   = 8'b0100_0000;
    localparam logic [7:0] F_ALU  = 8'b0010_0000;
    localparam logic [7:0] F_MEM  = 8'b0001_0000;
    localparam logic [7:0] F_RB   = 8'b0000_1100;
    localparam logic [7:0] F_HLT  = 8'b0000_0010;
    localparam logic [7:0] F_TMO  = 8'b0000_0001;

    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_IF   = 3'd1;
    localparam logic [2:0] P_ID   = 3'd2;
    localparam logic [2:0] P_ALU  = 3'd3;
    localparam logic [2:0] P_MEM  = 3'd4;
    localparam logic [2:0] P_WAIT = 3'd5;
    localparam logic [2:0] P_RB   = 3'd6;
    localparam logic [2:0] P_HLT  = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic       halt = 1'b0;
    logic       mem_access = 1'b0;
    logic       mem_ready = 1'b0;
    logic       IF_clk;
    logic       ID_clk;
    logic       ALU_clk;
    logic       MEM_clk;
    logic       RB_BR_clk;
    logic [2:0] phase;
    logic       instr_done;
    logic       halted;
    logic       mem_timeout;
`ifdef PHASE_SEQ_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phase_sequencer #(
        .MEM_WAIT_MAX (15),
        .WAIT_W       (8),
        .CNT_W        (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .halt        (halt),
        .mem_access  (mem_access),
        .mem_ready   (mem_ready),
        .IF_clk      (IF_clk),
        .ID_clk      (ID_clk),
        .ALU_clk     (ALU_clk),
        .MEM_clk     (MEM_clk),
        .RB_BR_clk   (RB_BR_clk),
        .phase       (phase),
        .instr_done  (instr_done),
        .halted      (halted),
        .mem_timeout (mem_timeout)
`ifdef PHASE_SEQ_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] obs();
        return {phase, IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk,
                instr_done, halted, mem_timeout};
    endfunction

    // Compare the current outputs without advancing time.
    task automatic look(input string tag, input logic [2:0] ph, input logic [7:0] fl);
        logic [10:0] o;
        o = obs();
        $display("check %-12s phase=%0d flags=%b", tag, o[10:8], o[7:0]);
        chk(tag, {21'd0, o}, {21'd0, ph, fl});
    endtask

    // Advance one clock, then compare just after the edge.
    task automatic cyc(input string tag, input logic [2:0] ph, input logic [7:0] fl);
        @(posedge clk);
        #1;
        look(tag, ph, fl);
    endtask

    task automatic perf(input string tag, input int exp_cyc, input int exp_ins);
`ifdef PHASE_SEQ_PERF_EN
        chk({tag, ".cycle_cnt"}, cycle_cnt, exp_cyc);
        chk({tag, ".instr_cnt"}, instr_cnt, exp_ins);
`else
        if (exp_cyc < 0 || exp_ins < 0) $display("negative counter expectation in %s", tag);
`endif
    endtask

    initial begin
        // ---- asynchronous reset at time 2, before any clock edge ----
        #2 rst_n = 1'b0;
        #2;
        look("rst", P_IDLE, F_NONE);
        repeat (2) @(posedge clk);
        #1;
        look("rst_hold", P_IDLE, F_NONE);
        perf("rst", 0, 0);

        // ---- three back-to-back non-memory instructions ----
        rst_n = 1'b1;
        run   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("nm.IF", P_IF, F_IF);
            cyc("nm.ID", P_ID, F_ID);
            cyc("nm.ALU", P_ALU, F_ALU);
            if (i == 2) run = 1'b0;       // sampled at RB of the third one
            cyc("nm.RB", P_RB, F_RB);
        end
        cyc("nm.IDLE0", P_IDLE, F_NONE);
        // 3 instructions x 4 active states (IF, ID, ALU, RB)
        perf("nm", 12, 3);
        cyc("nm.IDLE1", P_IDLE, F_NONE);
        cyc("nm.IDLE2", P_IDLE, F_NONE);
        perf("nm_idle", 12, 3);

        // ---- memory instruction, ready after two wait cycles ----
        // IDLE + IF + ID + ALU + MEM + 2 x WAIT + RB = 8 cycles
        mem_access = 1'b1;
        run        = 1'b1;
        cyc("m2.IF", P_IF, F_IF);
        cyc("m2.ID", P_ID, F_ID);
        cyc("m2.ALU", P_ALU, F_ALU);
        cyc("m2.MEM", P_MEM, F_MEM);
        cyc("m2.W1", P_WAIT, F_NONE);
        cyc("m2.W2", P_WAIT, F_NONE);
        mem_ready = 1'b1;
        cyc("m2.RB", P_RB, F_RB);
        mem_ready = 1'b0;

        // ---- ready arrives in the expiry cycle: no timeout ----
        cyc("mb.IF", P_IF, F_IF);
        cyc("mb.ID", P_ID, F_ID);
        cyc("mb.ALU", P_ALU, F_ALU);
        cyc("mb.MEM", P_MEM, F_MEM);
        for (int k = 1; k <= 15; k++) cyc("mb.W", P_WAIT, F_NONE);
        mem_ready = 1'b1;
        cyc("mb.RB", P_RB, F_RB);
        mem_ready = 1'b0;

        // ---- no ready: exactly 15 wait cycles then forced RB ----
        cyc("mt.IF", P_IF, F_IF);
        cyc("mt.ID", P_ID, F_ID);
        cyc("mt.ALU", P_ALU, F_ALU);
        cyc("mt.MEM", P_MEM, F_MEM);
        for (int k = 1; k <= 15; k++) cyc("mt.W", P_WAIT, F_NONE);
        cyc("mt.RB", P_RB, F_RB | F_TMO);
        mem_access = 1'b0;
        // timeout flag is sticky across the next instruction
        cyc("st.IF", P_IF, F_IF | F_TMO);
        cyc("st.ID", P_ID, F_ID | F_TMO);
        cyc("st.ALU", P_ALU, F_ALU | F_TMO);
        cyc("st.RB", P_RB, F_RB | F_TMO);

        // ---- halt in ALU of a memory instruction: no MEM, no RB ----
        mem_access = 1'b1;
        cyc("h.IF", P_IF, F_IF | F_TMO);
        cyc("h.ID", P_ID, F_ID | F_TMO);
        cyc("h.ALU", P_ALU, F_ALU | F_TMO);
        halt = 1'b1;
        cyc("h.HALT", P_HLT, F_HLT | F_TMO);
        halt = 1'b0;
        // active cycles: 12 + 7 + 20 + 20 + 4 + 3 = 66; instructions: 3+1+1+1+1
        perf("halt", 66, 7);
        for (int k = 0; k < 4; k++) begin
            run = ~run;
            cyc("h.toggle", P_HLT, F_HLT | F_TMO);
        end
        perf("halt_hold", 66, 7);

        // ---- reset leaves HALTED and clears the sticky flag ----
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        look("rst_halted", P_IDLE, F_NONE);
        perf("rst_halted", 0, 0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        run        = 1'b1;
        mem_access = 1'b1;
        mem_ready  = 1'b0;

        // ---- asynchronous reset while in MEM_WAIT ----
        cyc("ra.IF", P_IF, F_IF);
        cyc("ra.ID", P_ID, F_ID);
        cyc("ra.ALU", P_ALU, F_ALU);
        cyc("ra.MEM", P_MEM, F_MEM);
        cyc("ra.W1", P_WAIT, F_NONE);
        cyc("ra.W2", P_WAIT, F_NONE);
        #3 rst_n = 1'b0;
        #1;
        look("rst_async", P_IDLE, F_NONE);
        perf("rst_async", 0, 0);
        #2 rst_n = 1'b1;
        // first edge after release moves IDLE -> IF; old instruction is gone
        cyc("rr.IF", P_IF, F_IF);
        cyc("rr.ID", P_ID, F_ID);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
